// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: the opcode values
//   that matter for register-source usage, the controller state encoding and
//   two small decode helpers telling whether an opcode reads rs1 / rs2.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// -----------------------------------------------------------------------------
// hazard_shadow_pipe
//   Two-slot shadow of the destination info travelling through ID/EX and
//   EX/MEM, so the hazard controller can compare against it locally.
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   hold                    freeze both slots (data-memory wait)
//   flush                   clear both slots (taken branch)
//   insert                  ID holds a real instruction that is not bubbled
//   id_rd/memread/regwrite  decoder values of the instruction in ID
//   ex_*                    slot mirroring ID/EX
//   mem_*                   slot mirroring EX/MEM
// -----------------------------------------------------------------------------
module hazard_shadow_pipe #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              insert,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_memread,
  input  logic              id_regwrite,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_memread,
  output logic              ex_regwrite,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_memread,
  output logic              mem_regwrite
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd        <= '0;
      ex_memread   <= 1'b0;
      ex_regwrite  <= 1'b0;
      mem_rd       <= '0;
      mem_memread  <= 1'b0;
      mem_regwrite <= 1'b0;
    end else if (flush) begin
      ex_rd        <= '0;
      ex_memread   <= 1'b0;
      ex_regwrite  <= 1'b0;
      mem_rd       <= '0;
      mem_memread  <= 1'b0;
      mem_regwrite <= 1'b0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments, so the MEM slot takes the EX value
      // from before this edge and the two slots behave as a shift register.
      ex_rd        <= insert ? id_rd : '0;
      ex_memread   <= insert & id_memread;
      ex_regwrite  <= insert & id_regwrite;
      mem_rd       <= ex_rd;
      mem_memread  <= ex_memread;
      mem_regwrite <= ex_regwrite;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the 5-stage core. Inserts one bubble on a load-use
//   dependency, freezes the pipe while data memory is busy and squashes the
//   three younger instructions when a branch resolves taken in MEM.
//   Event priority: memory wait > taken branch > load-use.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid/opcode/rs1/rs2/rd instruction currently in ID
//   id_memread, id_regwrite    decoder controls, before bubbling
//   mem_br_taken               branch in MEM resolved taken
//   dmem_req, dmem_ready       outstanding data access / completes this cycle
//   bubble                     zero the ID control signals
//   pc_write, ifid_write       PC and IF/ID enables
//   ifid/idex/exmem_flush      stage clears
//   pipe_hold                  hold ID/EX, EX/MEM and MEM/WB
//   state                      controller state (RUN/STALL/WAIT/FLUSH)
//   stall_count                saturating count of cycles with pc_write=0
//   mem_timeout                sticky: a memory wait lasted TIMEOUT cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int TIMEOUT     = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_memread,
  input  logic                   id_regwrite,
  input  logic                   mem_br_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   bubble,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   pipe_hold,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_timeout
);

  localparam logic [6:0] WAIT_LAST = 7'(TIMEOUT - 1);

  state_t              cur_state, nxt_state;
  logic [6:0]          wait_cnt, wait_cnt_nxt;
  logic [REG_AW-1:0]   ex_rd, mem_rd;
  logic                ex_memread, ex_regwrite, mem_memread, mem_regwrite;
  logic                ev_wait, ev_branch, load_use;

  hazard_shadow_pipe #(.REG_AW(REG_AW)) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .hold         (pipe_hold),
    .flush        (idex_flush),
    .insert       (id_valid & ~bubble),
    .id_rd        (id_rd),
    .id_memread   (id_memread),
    .id_regwrite  (id_regwrite),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_memread  (mem_memread),
    .mem_regwrite (mem_regwrite)
  );

  // The MEM slot and EX regwrite are tracked for debug visibility only.
  logic unused_shadow;
  assign unused_shadow = ^{ex_regwrite, mem_rd, mem_memread, mem_regwrite};

  // Events are masked during reset so every output shows its reset value
  // immediately, even if the stage inputs are still active.
  assign ev_wait   = ~reset & dmem_req & ~dmem_ready;
  assign ev_branch = ~reset & mem_br_taken;
  assign load_use  = ~reset & id_valid & ex_memread & (ex_rd != '0) &
                     ((uses_rs1(id_opcode) & (ex_rd == id_rs1)) |
                      (uses_rs2(id_opcode) & (ex_rd == id_rs2)));

  always_comb begin
    // NOTE: every output gets a default before the priority chain, so no
    // path leaves a signal unassigned and no latch is inferred.
    bubble      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    nxt_state   = ST_RUN;
    if (ev_wait) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      nxt_state  = ST_WAIT;
    end else if (ev_branch) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      nxt_state   = ST_FLUSH;
    end else if (load_use) begin
      bubble     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      nxt_state  = ST_STALL;
    end
  end

  // Counts consecutive WAIT cycles; stops at the timeout value since the
  // timeout flag is sticky anyway.
  always_comb begin
    wait_cnt_nxt = '0;
    if (cur_state == ST_WAIT && nxt_state == ST_WAIT)
      wait_cnt_nxt = (wait_cnt == WAIT_LAST) ? wait_cnt : wait_cnt + 7'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state   <= ST_RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_cnt_nxt;
      if (wait_cnt_nxt == WAIT_LAST)
        mem_timeout <= 1'b1;
      if (!pc_write && stall_count != '1)
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  assign state = cur_state;

endmodule
